// File: rtl/dma_bus_arbiter.sv
// Two-master memory arbiter: CPU owns the bus, CP2 takes it via HOLD/HOLD_ACK.
// Optional forced-release watchdog is enabled with `define DMA_TIMEOUT_EN.
module dma_bus_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_HOLD_CYC = 4096
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wd,
  input  logic              cpu_busy,
  output logic [DATA_W-1:0] cpu_rd,
  output logic              cpu_stall,
  input  logic              dma_hold,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wd,
  output logic [DATA_W-1:0] dma_rd,
  output logic              dma_hold_ack,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd,
  input  logic              timeout_clr,
  output logic              timeout_irq
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DRAIN   = 3'd1,
    GRANT   = 3'd2,
    RELEASE = 3'd3
`ifdef DMA_TIMEOUT_EN
    ,
    LOCKOUT = 3'd4
`endif
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   set_to;
  logic   sel_dma;
  logic   is_rel;

`ifdef DMA_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_HOLD_CYC + 1);
  logic [CNT_W-1:0] cnt;
  logic             cnt_hit;

  assign cnt_hit = (cnt == CNT_W'(MAX_HOLD_CYC - 1));
`endif

  // State register; reset returns the bus to the CPU.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; a timeout only fires while HOLD is still high.
  always_comb begin
    state_nxt = state;
    set_to    = 1'b0;
    unique case (state)
      IDLE: begin
        if (dma_hold) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!dma_hold)     state_nxt = IDLE;
        else if (!cpu_busy) state_nxt = GRANT;
      end
      GRANT: begin
        if (!dma_hold) begin
          state_nxt = RELEASE;
        end
`ifdef DMA_TIMEOUT_EN
        else if (cnt_hit) begin
          state_nxt = LOCKOUT;
          set_to    = 1'b1;
        end
`endif
      end
      RELEASE: begin
        state_nxt = IDLE;
      end
`ifdef DMA_TIMEOUT_EN
      LOCKOUT: begin
        if (!dma_hold) state_nxt = IDLE;
      end
`endif
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output decode; the DMA mux is selected only from registered GRANT.
  always_comb begin
    sel_dma      = (state == GRANT);
    is_rel       = (state == RELEASE);
    cpu_stall    = (state == DRAIN) || sel_dma || is_rel;
    dma_hold_ack = sel_dma;
    mem_we       = cpu_we;
    mem_addr     = cpu_addr;
    mem_wd       = cpu_wd;
    if (sel_dma) begin
      mem_we   = dma_we;
      mem_addr = dma_addr;
      mem_wd   = dma_wd;
    end else if (is_rel) begin
      mem_we = 1'b0;
    end
  end

  assign cpu_rd = mem_rd;
  assign dma_rd = mem_rd;

`ifdef DMA_TIMEOUT_EN
  // GRANT cycle counter; cleared whenever the bus is not granted.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (state != GRANT) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Sticky timeout flag; a new timeout beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      timeout_irq <= 1'b0;
    end else if (set_to) begin
      timeout_irq <= 1'b1;
    end else if (timeout_clr) begin
      timeout_irq <= 1'b0;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg  = timeout_clr ^ set_to ^ (MAX_HOLD_CYC == 0);
  assign timeout_irq = 1'b0;
`endif

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Randomized bench for dma_bus_arbiter against a bus-ownership model.
// Honours DMA_TIMEOUT_EN with MAX_HOLD_CYC=8.
module tb_dma_bus_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int MAX = 8;
`ifdef DMA_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wd;
  logic          cpu_busy;
  logic [DW-1:0] cpu_rd;
  logic          cpu_stall;
  logic          dma_hold;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wd;
  logic [DW-1:0] dma_rd;
  logic          dma_hold_ack;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rd;
  logic          timeout_clr;
  logic          timeout_irq;

  int errors = 0;
  int checks = 0;

  // Model: who owns the bus and what phase of handover we are in.
  bit m_valid = 0;
  bit m_wait;
  bit m_dma;
  bit m_turn;
  bit m_lock;
  bit m_irq;
  int m_held;

  dma_bus_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_HOLD_CYC(MAX)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wd(cpu_wd), .cpu_busy(cpu_busy),
    .cpu_rd(cpu_rd), .cpu_stall(cpu_stall),
    .dma_hold(dma_hold), .dma_we(dma_we),
    .dma_addr(dma_addr), .dma_wd(dma_wd),
    .dma_rd(dma_rd), .dma_hold_ack(dma_hold_ack),
    .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wd(mem_wd), .mem_rd(mem_rd),
    .timeout_clr(timeout_clr),
    .timeout_irq(timeout_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic compare();
    logic          e_we;
    logic [AW-1:0] e_ad;
    logic [DW-1:0] e_wd;
    e_we = cpu_we;
    e_ad = cpu_addr;
    e_wd = cpu_wd;
    if (m_dma) begin
      e_we = dma_we;
      e_ad = dma_addr;
      e_wd = dma_wd;
    end else if (m_turn) begin
      e_we = 1'b0;
    end
    check("ack", 64'(dma_hold_ack), 64'(m_dma));
    check("stall", 64'(cpu_stall),
          64'(m_wait | m_dma | m_turn));
    check("mem_we", 64'(mem_we), 64'(e_we));
    check("mem_addr", 64'(mem_addr), 64'(e_ad));
    check("mem_wd", 64'(mem_wd), 64'(e_wd));
    check("cpu_rd", 64'(cpu_rd), 64'(mem_rd));
    check("dma_rd", 64'(dma_rd), 64'(mem_rd));
    check("irq", 64'(timeout_irq), 64'(m_irq));
  endtask

  task automatic advance();
    bit set;
    set = 0;
    if (!reset_n) begin
      m_valid = 1;
      m_wait  = 0;
      m_dma   = 0;
      m_turn  = 0;
      m_lock  = 0;
      m_irq   = 0;
      m_held  = 0;
      return;
    end
    if (!m_valid) return;
    if (m_dma) begin
      if (!dma_hold) begin
        m_dma  = 0;
        m_turn = 1;
      end else if (TO_EN && m_held == MAX - 1) begin
        m_dma  = 0;
        m_lock = 1;
        set    = 1;
      end else begin
        m_held++;
      end
    end else if (m_wait) begin
      if (!dma_hold) begin
        m_wait = 0;
      end else if (!cpu_busy) begin
        m_wait = 0;
        m_dma  = 1;
        m_held = 0;
      end
    end else if (m_turn) begin
      m_turn = 0;
    end else if (m_lock) begin
      if (!dma_hold) m_lock = 0;
    end else if (dma_hold) begin
      m_wait = 1;
    end
    if (set) m_irq = 1;
    else if (timeout_clr && TO_EN) m_irq = 0;
  endtask

  task automatic step(input bit rst, input bit hold,
                      input bit busy, input bit cwe,
                      input bit dwe, input bit clr);
    @(negedge clk);
    reset_n     = ~rst;
    dma_hold    = hold;
    cpu_busy    = busy;
    cpu_we      = cwe;
    dma_we      = dwe;
    timeout_clr = clr;
    cpu_addr    = $urandom;
    cpu_wd      = $urandom;
    dma_addr    = $urandom;
    dma_wd      = $urandom;
    mem_rd      = $urandom;
    #1;
    if (m_valid) compare();
    @(posedge clk);
    advance();
  endtask

  initial begin
    bit h;
    bit b;
    reset_n = 0; dma_hold = 0; cpu_busy = 0;
    cpu_we = 0; dma_we = 0; timeout_clr = 0;
    cpu_addr = '0; cpu_wd = '0; dma_addr = '0;
    dma_wd = '0; mem_rd = '0;
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 1, 0);

    // Grant with a fixed DMA write, checked directly.
    step(0, 1, 0, 0, 1, 0);
    step(0, 1, 0, 1, 1, 0);
    @(negedge clk);
    dma_hold = 1; dma_we = 1;
    dma_addr = 32'h40; dma_wd = 32'hDEADBEEF;
    #1;
    check("grant_we", 64'(mem_we), 64'd1);
    check("grant_addr", 64'(mem_addr), 64'h40);
    check("grant_wd", 64'(mem_wd), 64'hDEADBEEF);
    compare();
    @(posedge clk);
    advance();
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 1, 0);

    // Drain behind a busy CPU, then abort pulse.
    step(0, 1, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 0, 0);
    step(0, 1, 0, 1, 0, 0);
    step(0, 1, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 1, 0);
    step(0, 0, 1, 1, 1, 0);
    step(0, 0, 0, 1, 1, 0);

    // Release and re-grant after a 1-cycle HOLD gap.
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 1, 1, 0);

    // Reset mid-GRANT.
    step(1, 1, 0, 1, 1, 0);
    step(0, 0, 0, 1, 0, 0);

    // Stuck HOLD, then drop and clear.
    for (int i = 0; i < 14; i++) step(0, 1, 0, 1, 1, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);

    // Randomized traffic with sticky HOLD/busy levels.
    h = 0;
    b = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) h = ~h;
      if ($urandom_range(0, 3) == 0) b = ~b;
      step($urandom_range(0, 199) == 0, h, b,
           1'($urandom), 1'($urandom),
           $urandom_range(0, 9) == 0);
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
